// File: rtl/reg_file_sb.sv
// 2-read/1-write register file with a per-register pending (scoreboard) bit.
// Define REGFILE_BYPASS_EN for write-through forwarding of Din to the read ports.
module reg_file_sb #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [ADDR_W-1:0] Ard1,
  input  logic [ADDR_W-1:0] Ard2,
  output logic [DATA_W-1:0] Dout1,
  output logic [DATA_W-1:0] Dout2,
  output logic              Busy1,
  output logic              Busy2,
  input  logic [ADDR_W-1:0] Awr,
  input  logic [DATA_W-1:0] Din,
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] Arsv,
  input  logic              RsvEn
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic              wr_ok;
  logic              rsv_ok;
  logic [DATA_W-1:0] rd1, rd2;
  logic              pend1, pend2;

  // Register 0 and addresses beyond DEPTH are not writable and read as zero.
  function automatic logic addr_valid(input logic [ADDR_W-1:0] a);
    return (a != '0) && (int'(a) < DEPTH);
  endfunction

  assign wr_ok  = WrEn  && addr_valid(Awr);
  assign rsv_ok = RsvEn && addr_valid(Arsv);

  // NOTE: the array is reset element by element; this makes it flops, not RAM,
  // which is required because reset must clear every register asynchronously.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      pending <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (wr_ok && Awr == ADDR_W'(i)) mem[i] <= Din;
        // A new producer reserving the same register supersedes the writeback.
        if (rsv_ok && Arsv == ADDR_W'(i))
          pending[i] <= 1'b1;
        else if (wr_ok && Awr == ADDR_W'(i))
          pending[i] <= 1'b0;
      end
    end
  end

  // NOTE: defaults first in always_comb so no path leaves an output unassigned (no latch).
  always_comb begin
    rd1   = '0;
    rd2   = '0;
    pend1 = 1'b0;
    pend2 = 1'b0;
    if (addr_valid(Ard1)) begin
      rd1   = mem[Ard1];
      pend1 = pending[Ard1];
    end
    if (addr_valid(Ard2)) begin
      rd2   = mem[Ard2];
      pend2 = pending[Ard2];
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd1, fwd2, fwd_busy;

  // Forwarding is gated by reset so outputs stay zero while Rst_n is low.
  assign fwd1     = Rst_n && wr_ok && (Ard1 == Awr);
  assign fwd2     = Rst_n && wr_ok && (Ard2 == Awr);
  assign fwd_busy = rsv_ok && (Arsv == Awr);

  assign Dout1 = fwd1 ? Din      : rd1;
  assign Dout2 = fwd2 ? Din      : rd2;
  assign Busy1 = fwd1 ? fwd_busy : pend1;
  assign Busy2 = fwd2 ? fwd_busy : pend2;
`else
  assign Dout1 = rd1;
  assign Dout2 = rd2;
  assign Busy1 = pend1;
  assign Busy2 = pend2;
`endif

endmodule
